// File: rtl/decode_stage_pkg.sv
// Shared types for the decode/operand-fetch stage: ALU operation encodings,
// supported opcodes and the decoded-instruction record held in the output register.
package decode_stage_pkg;

    // Width of the decoded-instruction record; the stage's XLEN must match it.
    localparam int XLEN_DEF = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        ADD  = 3'b000,
        SLL  = 3'b001,
        SLT  = 3'b010,
        SLTU = 3'b011,
        XOR  = 3'b100,
        SR   = 3'b101,
        OR   = 3'b110,
        AND  = 3'b111
    } alu_funct3_e;

    typedef enum logic [6:0] {
        F7_NONE = 7'b0000000,
        NEG     = 7'b0100000
    } alu_funct7_e;

    typedef enum logic [6:0] {
        OP     = 7'b0110011,
        OP_IMM = 7'b0010011,
        LUI    = 7'b0110111
    } opcode_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0] op1;
        logic [XLEN_DEF-1:0] op2;
        alu_funct3_e         funct3;
        alu_funct7_e         funct7;
        logic [4:0]          rd;
        logic                illegal;
    } decoded_instr_t;

endpackage

// File: rtl/decode_stage_regfile.sv
// Integer register file: two combinational read ports, one synchronous write port,
// x0 hardwired to zero, and same-cycle write-to-read bypass.
module decode_stage_regfile
    import decode_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0][4:0]      raddr_i,
    output logic [1:0][XLEN-1:0] rdata_o,
    input  logic                 we_i,
    input  logic [4:0]           waddr_i,
    input  logic [XLEN-1:0]      wdata_i
);

    logic [XLEN-1:0] regs_q [NUM_REGS];

    // Entry 0 is only ever reset, so it folds away to a constant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != REG_ZERO)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_read
        assign rdata_o[gi] = (raddr_i[gi] == REG_ZERO)                ? '0 :
                             (we_i && (waddr_i == raddr_i[gi]))       ? wdata_i :
                                                                        regs_q[raddr_i[gi]];
    end

endmodule

// File: rtl/decode_stage.sv
// Decode/operand-fetch stage: decodes OP, OP-IMM and LUI into ALU operands and
// presents them from a valid/ready output register.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [31:0]     instr_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [XLEN-1:0] operand_1_o,
    output logic [XLEN-1:0] operand_2_o,
    output alu_funct3_e     funct3_o,
    output alu_funct7_e     funct7_o,
    output logic [4:0]      rd_o,
    output logic            illegal_o,
    output logic            out_valid_o,
    input  logic            out_ready_i
);

    logic [1:0][XLEN-1:0] rs_data;
    decoded_instr_t       dec_d;
    decoded_instr_t       out_d, out_q;
    logic                 out_valid_d, out_valid_q;
    logic                 accept;

    decode_stage_regfile #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .raddr_i ({instr_i[24:20], instr_i[19:15]}),
        .rdata_o (rs_data),
        .we_i    (wb_we_i),
        .waddr_i (wb_rd_i),
        .wdata_i (wb_data_i)
    );

    always_comb begin
        dec_d         = '0;
        dec_d.funct3  = ADD;
        dec_d.funct7  = F7_NONE;
        dec_d.illegal = 1'b0;
        case (instr_i[6:0])
            OP: begin
                dec_d.op1    = rs_data[0];
                dec_d.op2    = rs_data[1];
                dec_d.funct3 = alu_funct3_e'(instr_i[14:12]);
                dec_d.funct7 = alu_funct7_e'(instr_i[31:25]);
                dec_d.rd     = instr_i[11:7];
            end
            OP_IMM: begin
                dec_d.op1    = rs_data[0];
                dec_d.op2    = XLEN_DEF'($signed(instr_i[31:20]));
                dec_d.funct3 = alu_funct3_e'(instr_i[14:12]);
                // Only shift-right uses the upper immediate bits as an arithmetic/logical select.
                if (instr_i[14:12] == SR) begin
                    dec_d.funct7 = alu_funct7_e'(instr_i[31:25]);
                end
                dec_d.rd     = instr_i[11:7];
            end
            LUI: begin
                dec_d.op2 = XLEN_DEF'($signed({instr_i[31:12], 12'b0}));
                dec_d.rd  = instr_i[11:7];
            end
            default: dec_d.illegal = 1'b1;
        endcase
    end

    assign instr_ready_o = !out_valid_q || out_ready_i;
    assign accept        = instr_valid_i && instr_ready_o;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_d       = dec_d;
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign operand_1_o = out_q.op1;
    assign operand_2_o = out_q.op2;
    assign funct3_o    = out_q.funct3;
    assign funct7_o    = out_q.funct7;
    assign rd_o        = out_q.rd;
    assign illegal_o   = out_q.illegal;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: decode, handshake stalls, bypass and reset.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] instr_i = '0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic        wb_we_i = 1'b0;
    logic [4:0]  wb_rd_i = '0;
    logic [31:0] wb_data_i = '0;
    logic [31:0] operand_1_o, operand_2_o;
    alu_funct3_e funct3_o;
    alu_funct7_e funct7_o;
    logic [4:0]  rd_o;
    logic        illegal_o, out_valid_o;
    logic        out_ready_i = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    decode_stage dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .wb_we_i       (wb_we_i),
        .wb_rd_i       (wb_rd_i),
        .wb_data_i     (wb_data_i),
        .operand_1_o   (operand_1_o),
        .operand_2_o   (operand_2_o),
        .funct3_o      (funct3_o),
        .funct7_o      (funct7_o),
        .rd_o          (rd_o),
        .illegal_o     (illegal_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] op1, input logic [31:0] op2,
                             input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                             input logic ill);
        check({tag, ".valid"},   {31'b0, out_valid_o}, 32'd1);
        check({tag, ".op1"},     operand_1_o, op1);
        check({tag, ".op2"},     operand_2_o, op2);
        check({tag, ".funct3"},  {29'b0, funct3_o}, {29'b0, f3});
        check({tag, ".funct7"},  {25'b0, funct7_o}, {25'b0, f7});
        check({tag, ".rd"},      {27'b0, rd_o}, {27'b0, rd});
        check({tag, ".illegal"}, {31'b0, illegal_o}, {31'b0, ill});
    endtask

    // Presents one instruction for a single edge; returns at the following falling edge.
    task automatic send(input logic [31:0] instr);
        @(negedge clk_i);
        instr_i       = instr;
        instr_valid_i = 1'b1;
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        $display("send instr=%h out_valid=%0b op1=%h op2=%h rd=%0d", instr, out_valid_o,
                 operand_1_o, operand_2_o, rd_o);
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        @(negedge clk_i);
        wb_we_i   = 1'b1;
        wb_rd_i   = rd;
        wb_data_i = data;
        @(negedge clk_i);
        wb_we_i   = 1'b0;
        $display("writeback x%0d=%h", rd, data);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        check("rst.valid",  {31'b0, out_valid_o}, 32'd0);
        check("rst.op1",    operand_1_o, 32'd0);
        check("rst.op2",    operand_2_o, 32'd0);
        check("rst.funct3", {29'b0, funct3_o}, 32'd0);
        check("rst.rd",     {27'b0, rd_o}, 32'd0);
        check("rst.illegal",{31'b0, illegal_o}, 32'd0);
        check("rst.ready",  {31'b0, instr_ready_o}, 32'd1);
        rst_ni = 1'b1;

        // ADDI x1,x0,5
        send(32'h00500093);
        check_out("addi", 32'd0, 32'd5, 3'b000, 7'h00, 5'd1, 1'b0);

        wb_write(5'd1, 32'd7);
        wb_write(5'd2, 32'd3);
        // SUB x3,x1,x2
        send(32'h402081B3);
        check_out("sub", 32'd7, 32'd3, 3'b000, 7'b0100000, 5'd3, 1'b0);

        // ADDI x2,x0,-1
        send(32'hFFF00113);
        check_out("addi_neg", 32'd0, 32'hFFFFFFFF, 3'b000, 7'h00, 5'd2, 1'b0);

        // LUI x5,0x12345
        send(32'h123452B7);
        check_out("lui", 32'd0, 32'h12345000, 3'b000, 7'h00, 5'd5, 1'b0);

        // Stall: ADDI x6,x1,16 held while SRAI x7,x2,4 waits
        @(negedge clk_i);
        out_ready_i   = 1'b0;
        instr_i       = 32'h01008313;
        instr_valid_i = 1'b1;
        @(negedge clk_i);
        instr_i = 32'h40415393;
        check("stall.ready", {31'b0, instr_ready_o}, 32'd0);
        check_out("stall.first", 32'd7, 32'h10, 3'b000, 7'h00, 5'd6, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("stall.ready_hold", {31'b0, instr_ready_o}, 32'd0);
            check_out("stall.hold", 32'd7, 32'h10, 3'b000, 7'h00, 5'd6, 1'b0);
        end
        out_ready_i = 1'b1;
        #1;
        check("stall.release_ready", {31'b0, instr_ready_o}, 32'd1);
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        check_out("stall.second", 32'd3, 32'h404, 3'b101, 7'b0100000, 5'd7, 1'b0);

        // Bypass: write x1 while reading it in ADD x4,x1,x0
        @(negedge clk_i);
        wb_we_i       = 1'b1;
        wb_rd_i       = 5'd1;
        wb_data_i     = 32'hDEADBEEF;
        instr_i       = 32'h00008233;
        instr_valid_i = 1'b1;
        @(negedge clk_i);
        wb_we_i       = 1'b0;
        instr_valid_i = 1'b0;
        check_out("bypass", 32'hDEADBEEF, 32'd0, 3'b000, 7'h00, 5'd4, 1'b0);
        send(32'h00008233);
        check_out("bypass_commit", 32'hDEADBEEF, 32'd0, 3'b000, 7'h00, 5'd4, 1'b0);

        // x0 write with same-cycle read of x0 (ADD x9,x0,x0), then later read
        @(negedge clk_i);
        wb_we_i       = 1'b1;
        wb_rd_i       = 5'd0;
        wb_data_i     = 32'h55;
        instr_i       = 32'h000004B3;
        instr_valid_i = 1'b1;
        @(negedge clk_i);
        wb_we_i       = 1'b0;
        instr_valid_i = 1'b0;
        check_out("x0_bypass", 32'd0, 32'd0, 3'b000, 7'h00, 5'd9, 1'b0);
        send(32'h000004B3);
        check_out("x0_read", 32'd0, 32'd0, 3'b000, 7'h00, 5'd9, 1'b0);

        // Unknown opcode
        send(32'h0000007F);
        check_out("illegal", 32'd0, 32'd0, 3'b000, 7'h00, 5'd0, 1'b1);

        // Asynchronous reset while an output is held
        out_ready_i = 1'b0;
        send(32'h01008313);
        check("prereset.valid", {31'b0, out_valid_o}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst.valid", {31'b0, out_valid_o}, 32'd0);
        check("async_rst.op1",   operand_1_o, 32'd0);
        @(negedge clk_i);
        rst_ni      = 1'b1;
        out_ready_i = 1'b1;
        // ADD x9,x1,x2: both sources were nonzero before reset
        send(32'h002084B3);
        check_out("post_rst", 32'd0, 32'd0, 3'b000, 7'h00, 5'd9, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
